// File: rtl/wb_cmd_master_pkg.sv
// Shared types for the Wishbone command master: response status codes, FSM states
// and a counter-width helper.
package wb_cmd_master_pkg;

  typedef enum logic [1:0] {
    RspOk      = 2'd0,
    RspErr     = 2'd1,
    RspTimeout = 2'd2,
    RspRetry   = 2'd3
  } t_wb_rsp_status;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StGap,
    StResp
  } t_wb_cmd_state;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_watchdog_counter.sv
// Per-attempt watchdog: counts active bus cycles and flags the last allowed one.
// TIMEOUT = 0 disables expiry.
module wb_watchdog_counter
  import wb_cmd_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W       = cnt_width(TIMEOUT);
  localparam int unsigned LastVal = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [W-1:0] Last   = LastVal[W-1:0];

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // Expires during the TIMEOUT-th active cycle so the bus drops right after it.
  assign expired = (TIMEOUT != 0) && enable && (cnt_q == Last);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone B4 initiator: one command in, one classic or pipelined single cycle on the
// bus, one response out. Handles rty by bounded retry and stuck slaves by a watchdog.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          PIPELINED  = 1'b1,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_adr,
  input  logic [DATA_WIDTH/8-1:0] cmd_sel,
  input  logic [DATA_WIDTH-1:0]   cmd_dat,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_dat,
  output logic [1:0]              rsp_status,
  output logic                    wb_cyc,
  output logic                    wb_stb,
  output logic                    wb_we,
  output logic [ADDR_WIDTH-1:0]   wb_adr,
  output logic [DATA_WIDTH/8-1:0] wb_sel,
  output logic [DATA_WIDTH-1:0]   wb_dato,
  input  logic                    wb_ack,
  input  logic                    wb_err,
  input  logic                    wb_rty,
  input  logic                    wb_stall,
  input  logic [DATA_WIDTH-1:0]   wb_dati
);

  localparam int unsigned SelWidth   = DATA_WIDTH / 8;
  localparam int unsigned RetryWidth = cnt_width(MAX_RETRY);
  localparam logic [RetryWidth-1:0] RetryMax = MAX_RETRY[RetryWidth-1:0];

  t_wb_cmd_state           state_q, state_d;
  logic [RetryWidth-1:0]   retry_q, retry_d;
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [SelWidth-1:0]     sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   dato_q, dato_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_dat_q, rsp_dat_d;
  t_wb_rsp_status          rsp_status_q, rsp_status_d;

  logic wd_clear, wd_enable, wd_expired;

  wb_watchdog_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  assign wd_enable = (state_q == StReq) || (state_q == StWait);
  assign wd_clear  = (state_d == StReq) && (state_q != StReq);

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    we_d         = we_q;
    adr_d        = adr_q;
    sel_d        = sel_q;
    dato_d       = dato_q;
    rsp_valid_d  = 1'b0;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d = StReq;
          retry_d = '0;
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          sel_d   = cmd_sel;
          dato_d  = cmd_dat;
        end
      end
      StReq, StWait: begin
        // Termination priority: err > rty > ack; the watchdog loses to any termination.
        if (wb_err) begin
          state_d      = StResp;
          rsp_valid_d  = 1'b1;
          rsp_status_d = RspErr;
          rsp_dat_d    = '0;
        end else if (wb_rty) begin
          if (retry_q < RetryMax) begin
            retry_d = retry_q + RetryWidth'(1);
            state_d = StGap;
          end else begin
            state_d      = StResp;
            rsp_valid_d  = 1'b1;
            rsp_status_d = RspRetry;
            rsp_dat_d    = '0;
          end
        end else if (wb_ack) begin
          state_d      = StResp;
          rsp_valid_d  = 1'b1;
          rsp_status_d = RspOk;
          rsp_dat_d    = we_q ? '0 : wb_dati;
        end else if (wd_expired) begin
          state_d      = StResp;
          rsp_valid_d  = 1'b1;
          rsp_status_d = RspTimeout;
          rsp_dat_d    = '0;
        end else if ((state_q == StReq) && PIPELINED && !wb_stall) begin
          state_d = StWait;
        end
      end
      StGap: state_d = StReq;
      StResp: begin
        state_d = StIdle;
        retry_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus and handshake outputs are registered copies of the next state.
  assign cyc_d       = (state_d == StReq) || (state_d == StWait);
  assign stb_d       = (state_d == StReq);
  assign cmd_ready_d = (state_d == StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      retry_q      <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      sel_q        <= '0;
      dato_q       <= '0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= RspOk;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      sel_q        <= sel_d;
      dato_q       <= dato_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_dat    = rsp_dat_q;
  assign rsp_status = rsp_status_q;
  assign wb_cyc     = cyc_q;
  assign wb_stb     = stb_q;
  assign wb_we      = we_q;
  assign wb_adr     = adr_q;
  assign wb_sel     = sel_q;
  assign wb_dato    = dato_q;

endmodule
